vga_timing: RTL
===============

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 40, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 128, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 88, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 600, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 1, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 4, vertical sync width in lines.
REQ-008 SHALL have parameter V_BP, default 23, vertical back porch in lines.
REQ-009 SHALL have port clk, input, 1, pixel clock; all logic on its rising edge.
REQ-010 SHALL have port rst, input, 1, reset (synchronous, active-high).
REQ-011 SHALL have port en, input, 1, pixel advance enable.
REQ-012 SHALL have port vga_out, vga_if.out: hcount 11, vcount 11, hsync 1, vsync 1, hblnk 1, vblnk 1, rgb 12.
REQ-013 SHALL have port sof, output, 1, start-of-frame pulse.

Function
REQ-014 SHALL derive H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056) and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (default 628).
REQ-015 SHALL register every output, and all outputs in one cycle SHALL describe the same (hcount,vcount) pixel. Sync/blank SHALL be computed from next-state counts, not delayed by one cycle.
REQ-016 SHALL, on a cycle with en=1, advance hcount by 1. At hcount=H_TOTAL-1 it SHALL wrap to 0 and vcount SHALL advance by 1.
REQ-017 SHALL wrap vcount from V_TOTAL-1 to 0 in the same cycle that hcount wraps; hcount and vcount SHALL never exceed TOTAL-1.
REQ-018 SHALL, with en=0, hold every output unchanged, except that sof SHALL be 0.
REQ-019 SHALL drive hblnk=1 exactly when hcount>=H_ACTIVE (800..1055 at defaults).
REQ-020 SHALL drive vblnk=1 exactly when vcount>=V_ACTIVE (600..627 at defaults).
REQ-021 SHALL drive hsync=1 exactly when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (840..967), positive polarity.
REQ-022 SHALL drive vsync=1 exactly when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (601..604), positive polarity.
REQ-023 SHALL drive rgb=12'h000 constantly; pixel colour is added by downstream draw stages.
REQ-024 SHALL drive sof=1 for exactly one cycle: the enabled cycle in which the outputs change to (hcount=0, vcount=0).
REQ-025 SHALL give the active-to-active line period as H_TOTAL enabled cycles and the frame period as H_TOTAL*V_TOTAL enabled cycles (663168 at defaults), with no dropped or repeated pixel.

Reset
REQ-026 SHALL, while rst=1, drive hcount=H_TOTAL-1, vcount=V_TOTAL-1, hblnk=1, vblnk=1, hsync=0, vsync=0, rgb=0, sof=0.
REQ-027 SHALL, on the first en=1 cycle after rst falls, output (0,0) with sof=1, so every frame (including the first) is flagged.
REQ-028 SHALL let rst asserted mid-frame take priority over en and reach the REQ-026 state on the next edge.

Verification
REQ-029 SHALL pass: release rst with en=1 -> after the first edge, hcount=0, vcount=0, sof=1, hblnk=0, vblnk=0; next cycle hcount=1, sof=0.
REQ-030 SHALL pass: run one line -> hblnk rises at hcount=800; hsync is high for exactly 128 cycles (840..967); hcount wraps 1055->0 while vcount goes 0->1.
REQ-031 SHALL pass: run a full frame -> vsync is high for exactly 4*1056 cycles (lines 601..604); vblnk is high for lines 600..627; sof recurs after exactly 663168 cycles.
REQ-032 SHALL pass: hold en=0 for 10 cycles at hcount=1055, vcount=627 -> all outputs frozen, sof=0; the next en=1 cycle gives (0,0) with sof=1.
REQ-033 SHALL pass: assert rst at hcount=400, vcount=300 -> next edge shows hcount=1055, vcount=627, hblnk=vblnk=1, sync=0, sof=0.
REQ-034 SHALL pass: parameter override H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 -> line of 12 cycles, hsync at hcount 9..10, frame of 84 cycles.

Source files
------------

// File: rtl/vga_if.sv
// Raster timing bundle passed between the VGA timing generator and downstream draw stages.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing.sv
// VGA raster counter: produces registered pixel coordinates, sync and blanking for one
// (hcount, vcount) pixel per enabled cycle, plus a one-cycle start-of-frame flag.
module vga_timing #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    vga_if.out   vga_out,
    output logic sof
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_BLNK_BEG = 11'(H_ACTIVE);
    localparam logic [10:0] V_BLNK_BEG = 11'(V_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_q,  hsync_d;
    logic        vsync_q,  vsync_d;
    logic        hblnk_q,  hblnk_d;
    logic        vblnk_q,  vblnk_d;
    logic        sof_q,    sof_d;
    logic [10:0] h_next, v_next;

    // Sync and blank decode the *next* counts so every registered output refers to one pixel.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        hblnk_d  = hblnk_q;
        vblnk_d  = vblnk_q;
        sof_d    = 1'b0;

        h_next = (hcount_q == H_LAST) ? 11'd0 : hcount_q + 11'd1;
        v_next = vcount_q;
        if (hcount_q == H_LAST) begin
            v_next = (vcount_q == V_LAST) ? 11'd0 : vcount_q + 11'd1;
        end

        if (en) begin
            hcount_d = h_next;
            vcount_d = v_next;
            hblnk_d  = (h_next >= H_BLNK_BEG);
            vblnk_d  = (v_next >= V_BLNK_BEG);
            hsync_d  = (h_next >= H_SYNC_BEG) && (h_next < H_SYNC_END);
            vsync_d  = (v_next >= V_SYNC_BEG) && (v_next < V_SYNC_END);
            sof_d    = (h_next == 11'd0) && (v_next == 11'd0);
        end
    end

    // Reset parks the counters on the last pixel so the first enabled cycle lands on (0,0).
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            hcount_q <= H_LAST;
            vcount_q <= V_LAST;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblnk_q  <= 1'b1;
            vblnk_q  <= 1'b1;
            sof_q    <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblnk_q  <= hblnk_d;
            vblnk_q  <= vblnk_d;
            sof_q    <= sof_d;
        end
    end

    assign vga_out.hcount = hcount_q;
    assign vga_out.vcount = vcount_q;
    assign vga_out.hsync  = hsync_q;
    assign vga_out.vsync  = vsync_q;
    assign vga_out.hblnk  = hblnk_q;
    assign vga_out.vblnk  = vblnk_q;
    assign vga_out.rgb    = 12'h000;
    assign sof            = sof_q;

endmodule
